// File: rtl/nibble_bus_pkg.sv
// Shared constants for the nibble bus arbiter: widths, FSM bit indices,
// strobe bit positions and requester port ids.
package nibble_bus_pkg;
   localparam int ADDR_W = 10;
   localparam int NIB_W  = 4;

   // One-hot state bit positions
   localparam int S_IDLE = 0;
   localparam int S_ADDR = 1;
   localparam int S_XFER = 2;
   localparam int S_DONE = 3;

   localparam int STB_ADDR = 0;
   localparam int STB_XFER = 1;

   localparam logic PORT_F = 1'b0;
   localparam logic PORT_D = 1'b1;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_ADDR = 4'b0010,
      ST_XFER = 4'b0100,
      ST_DONE = 4'b1000
   } state_t;
endpackage

// File: rtl/nb_rr_arb2.sv
// Two-requester arbiter: round-robin on contention, or fixed data-port
// priority when prio_fixed is set. Grant is one-hot, indexed by port id.
module nb_rr_arb2
   import nibble_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio_fixed,
   input  logic       last,
   output logic [1:0] grant
);
   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = 2'b00;
         if (prio_fixed || last == PORT_F) grant[PORT_D] = 1'b1;
         else                              grant[PORT_F] = 1'b1;
      end
   end
endmodule

// File: rtl/nibble_bus_arbiter.sv
// Shares one multiplexed nibble bus between a fetch and a data requester.
// Each transaction runs IDLE -> ADDR -> XFER (stretchable) -> DONE.
module nibble_bus_arbiter
   import nibble_bus_pkg::*;
#(
   parameter int WAIT_MAX  = 7,
   parameter int DATA_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [NIB_W-1:0]  f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [NIB_W-1:0]  d_wdata,
   output logic              d_ack,
   output logic [NIB_W-1:0]  d_rdata,
   output logic              ack_err,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [1:0]        bus_strobe,
   output logic              bus_we,
   output logic [NIB_W-1:0]  bus_dout,
   output logic [NIB_W-1:0]  bus_oe,
   input  logic [NIB_W-1:0]  bus_din,
   input  logic              bus_wait,
   output logic              busy
);
   localparam logic [3:0] WMAX = 4'(WAIT_MAX);

   state_t              state_q, state_d;
   logic                gnt_q, last_q, we_q, err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [NIB_W-1:0]    wdata_q, f_rdata_q, d_rdata_q;
   logic [3:0]          wait_cnt;
   logic [1:0]          grant;
   logic                any_req, timeout;

   assign any_req = f_req | d_req;
   assign timeout = state_q[S_XFER] & bus_wait & (wait_cnt == WMAX);

   nb_rr_arb2 u_arb (
      .req        ({d_req, f_req}),
      .prio_fixed (DATA_PRIO != 0),
      .last       (last_q),
      .grant      (grant)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (any_req) state_d = ST_ADDR;
         ST_ADDR: state_d = ST_XFER;
         ST_XFER: if (!bus_wait || timeout) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q     <= PORT_F;
         last_q    <= PORT_D;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
         wait_cnt  <= '0;
      end else if (state_q[S_IDLE] && any_req) begin
         gnt_q    <= grant[PORT_D] ? PORT_D : PORT_F;
         last_q   <= grant[PORT_D] ? PORT_D : PORT_F;
         addr_q   <= grant[PORT_D] ? d_addr : f_addr;
         we_q     <= grant[PORT_D] & d_we;
         wdata_q  <= d_wdata;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else if (state_q[S_XFER]) begin
         if (bus_wait) begin
            if (timeout) begin
               // A timed-out read returns zero rather than stale or floating data
               err_q <= 1'b1;
               if (!we_q && gnt_q == PORT_F) f_rdata_q <= '0;
               if (!we_q && gnt_q == PORT_D) d_rdata_q <= '0;
            end else begin
               wait_cnt <= wait_cnt + 4'd1;
            end
         end else if (!we_q) begin
            if (gnt_q == PORT_F) f_rdata_q <= bus_din;
            else                 d_rdata_q <= bus_din;
         end
      end
   end

   assign busy                 = ~state_q[S_IDLE];
   assign bus_addr             = addr_q;
   assign bus_strobe[STB_ADDR] = state_q[S_ADDR];
   assign bus_strobe[STB_XFER] = state_q[S_XFER];
   assign bus_we               = we_q & (state_q[S_ADDR] | state_q[S_XFER]);
   assign bus_oe               = {NIB_W{we_q & state_q[S_XFER]}};
   assign bus_dout             = (we_q & state_q[S_XFER]) ? wdata_q : '0;
   assign f_ack                = state_q[S_DONE] & (gnt_q == PORT_F);
   assign d_ack                = state_q[S_DONE] & (gnt_q == PORT_D);
   assign ack_err              = state_q[S_DONE] & err_q;
   assign f_rdata              = f_rdata_q;
   assign d_rdata              = d_rdata_q;
endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Directed bench for nibble_bus_arbiter (WAIT_MAX=3, round-robin):
// reset, fetch read, data write, contention, timeout, reset abort.
module tb_nibble_bus_arbiter;
   logic       clk = 0;
   logic       rst;
   logic       f_req, d_req, d_we, bus_wait;
   logic [9:0] f_addr, d_addr, bus_addr;
   logic [3:0] d_wdata, bus_din, f_rdata, d_rdata, bus_dout, bus_oe;
   logic       f_ack, d_ack, ack_err, bus_we, busy;
   logic [1:0] bus_strobe;

   int n_chk = 0;
   int n_fail = 0;

   nibble_bus_arbiter #(.WAIT_MAX(3), .DATA_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .ack_err(ack_err),
      .bus_addr(bus_addr), .bus_strobe(bus_strobe), .bus_we(bus_we),
      .bus_dout(bus_dout), .bus_oe(bus_oe), .bus_din(bus_din),
      .bus_wait(bus_wait), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  acks;
      logic [3:0] order;
      rst = 1; f_req = 0; d_req = 0; d_we = 0; bus_wait = 0;
      f_addr = '0; d_addr = '0; d_wdata = '0; bus_din = '0;
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_strobe", bus_strobe, 0);
      chk("rst_oe", bus_oe, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_acks", {f_ack, d_ack, ack_err, bus_we}, 0);
      chk("rst_rdata", {f_rdata, d_rdata, bus_dout}, 0);
      rst = 0;

      // Fetch read
      f_req = 1; f_addr = 10'h155; bus_din = 4'hA;
      tick();
      chk("f_addr_phase", {bus_strobe, bus_addr}, {2'b01, 10'h155});
      chk("f_busy", busy, 1);
      tick();
      chk("f_xfer", {bus_strobe, bus_oe}, {2'b10, 4'h0});
      tick();
      chk("f_done", {f_ack, d_ack, ack_err, bus_strobe}, {3'b100, 2'b00});
      chk("f_rdata", f_rdata, 4'hA);
      f_req = 0; bus_din = 4'h0;
      tick();
      chk("f_idle", {busy, f_ack}, 0);
      chk("f_rdata_hold", f_rdata, 4'hA);

      // Data write
      d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 4'h5;
      tick();
      chk("w_addr_phase", {bus_strobe, bus_we, bus_addr}, {2'b01, 1'b1, 10'h3FF});
      chk("w_addr_oe", bus_oe, 0);
      tick();
      chk("w_xfer", {bus_strobe, bus_oe, bus_dout}, {2'b10, 4'hF, 4'h5});
      tick();
      chk("w_done", {d_ack, f_ack, ack_err, bus_oe}, {3'b100, 4'h0});
      d_req = 0; d_we = 0;
      tick();
      chk("w_idle", {busy, d_ack}, 0);

      // Contention: both held, fetch wins first, then alternate
      f_req = 1; d_req = 1; f_addr = 10'h011; d_addr = 10'h022; bus_din = 4'h6;
      acks = 0; order = '0;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("c_no_dual_ack", f_ack & d_ack, 0);
         if (f_ack || d_ack) begin
            if (acks < 4) order[acks] = d_ack;
            acks++;
         end
      end
      f_req = 0; d_req = 0;
      chk("c_ack_count", acks, 4);
      chk("c_order_FDFD", order, 4'b1010);
      tick();
      chk("c_idle", busy, 0);
      chk("c_rdata", {f_rdata, d_rdata}, 8'h66);

      // Timeout on a data read; fetch raised mid-transaction is ignored
      bus_wait = 1; bus_din = 4'hB; d_req = 1; d_we = 0; d_addr = 10'h012;
      tick();
      chk("t_addr", bus_addr, 10'h012);
      f_req = 1; f_addr = 10'h3C0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t_xfer_len", {bus_strobe, bus_addr}, {2'b10, 10'h012});
      end
      tick();
      chk("t_done", {d_ack, f_ack, ack_err}, 3'b101);
      chk("t_rdata_zero", d_rdata, 0);
      d_req = 0; f_req = 0; bus_wait = 0;
      tick();
      chk("t_idle", {busy, ack_err}, 0);

      // Reset during XFER of a write
      d_req = 1; d_we = 1; d_addr = 10'h0AA; d_wdata = 4'hC;
      tick(); tick();
      chk("r_xfer_oe", bus_oe, 4'hF);
      rst = 1;
      tick();
      chk("r_abort", {busy, bus_oe, bus_strobe, d_ack, f_ack}, 0);
      chk("r_rdata_clr", {f_rdata, d_rdata}, 0);
      rst = 0; d_req = 0; d_we = 0;
      tick();
      chk("r_no_ack", {d_ack, f_ack, busy}, 0);

      f_req = 1; f_addr = 10'h2C3; bus_din = 4'h9;
      tick();
      chk("r_f_addr", {bus_strobe, bus_addr}, {2'b01, 10'h2C3});
      tick(); tick();
      chk("r_f_done", {f_ack, d_ack, ack_err, f_rdata}, {3'b100, 4'h9});
      f_req = 0;
      tick();
      chk("r_f_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
